inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues word addresses to instruction memory and
// buffers returned words in a 2-entry FIFO toward decode.
// Optional macro INST_FETCH_PERF_CNT_EN adds fetch_count / stall_count outputs.
//
// state  | meaning
// IDLE   | not fetching; PC held except by redirect
// RUN    | issuing requests, one per cycle when FIFO has room
// DRAIN  | run dropped; finishing the in-flight request, FIFO still presented
module inst_fetch_ctrl #(
  parameter int ADDR_BIT_WIDTH = 11,
  parameter int DATA_BIT_WIDTH = 32,
  parameter logic [ADDR_BIT_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      redirect_valid,
  input  logic [ADDR_BIT_WIDTH-1:0] redirect_pc,
  output logic [ADDR_BIT_WIDTH-1:0] imemAddr,
  input  logic [DATA_BIT_WIDTH-1:0] imemData,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [DATA_BIT_WIDTH-1:0] inst_data,
  output logic [ADDR_BIT_WIDTH-1:0] inst_pc,
  output logic                      busy
`ifdef INST_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]               fetch_count,
  output logic [31:0]               stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_BIT_WIDTH-1:0] pc, pc_nxt;
  logic                      inflight;
  logic [ADDR_BIT_WIDTH-1:0] inflight_pc;

  logic [DATA_BIT_WIDTH-1:0] fifo_data [2];
  logic [ADDR_BIT_WIDTH-1:0] fifo_pc   [2];
  logic                      wr_ptr;
  logic                      rd_ptr;
  logic [1:0]                count;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign imemAddr   = pc;
  assign inst_valid = (count != 2'd0);
  assign inst_data  = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign busy       = (state != S_IDLE);

  assign pop       = inst_valid & inst_ready;
  assign push      = inflight & ~redirect_valid;
  assign occupancy = {1'b0, count} + {2'b00, inflight};

  // Issue only if the slot freed by this cycle's pop leaves room for the return.
  assign issue = (state == S_RUN) && !redirect_valid &&
                 (occupancy < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!run) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (run)
          state_nxt = S_RUN;
        else if ((count == 2'd0) && !inflight)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (redirect_valid)
      pc_nxt = redirect_pc;
    else if (issue)
      pc_nxt = pc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= issue;
      if (issue)
        inflight_pc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // A pop in this cycle still completes; its entry is simply dropped with the rest.
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= imemData;
        fifo_pc[wr_ptr]   <= inflight_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef INST_FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      fetch_count <= fetch_count + {31'd0, pop};
      stall_count <= stall_count + {31'd0, inst_valid & ~inst_ready};
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: expected PCs are queued as stimulus is
// driven and checked against each accepted instruction.
module tb_inst_fetch_ctrl;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  // dut0: RESET_PC = 0
  logic          reset, run, redirect_valid, inst_ready;
  logic [AW-1:0] redirect_pc, imemAddr, inst_pc;
  logic [DW-1:0] imemData, inst_data;
  logic          inst_valid, busy;
  logic [AW-1:0] maddr_q;
  // dut1: RESET_PC = 0x7FE
  logic          reset_w, run_w, redirect_valid_w, inst_ready_w;
  logic [AW-1:0] redirect_pc_w, imemAddr_w, inst_pc_w;
  logic [DW-1:0] imemData_w, inst_data_w;
  logic          inst_valid_w, busy_w;
  logic [AW-1:0] maddr_q_w;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0]   fetch_count, stall_count, fetch_count_w, stall_count_w;
`endif

  inst_fetch_ctrl #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .RESET_PC(11'h000)) dut0 (
    .clk(clk), .reset(reset), .run(run), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imemAddr(imemAddr), .imemData(imemData),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .busy(busy)
`ifdef INST_FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  inst_fetch_ctrl #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .RESET_PC(11'h7FE)) dut1 (
    .clk(clk), .reset(reset_w), .run(run_w), .redirect_valid(redirect_valid_w),
    .redirect_pc(redirect_pc_w), .imemAddr(imemAddr_w), .imemData(imemData_w),
    .inst_valid(inst_valid_w), .inst_ready(inst_ready_w), .inst_data(inst_data_w),
    .inst_pc(inst_pc_w), .busy(busy_w)
`ifdef INST_FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count_w), .stall_count(stall_count_w)
`endif
  );

  function automatic logic [DW-1:0] mem0(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a};
  endfunction

  function automatic logic [DW-1:0] mem1(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} ^ 32'hDEAD_0000;
  endfunction

  // Memory latches the address on the falling edge; word is returned one edge later.
  always @(negedge clk) begin
    maddr_q   <= imemAddr;
    maddr_q_w <= imemAddr_w;
  end
  always @(posedge clk) begin
    imemData   <= mem0(maddr_q);
    imemData_w <= mem1(maddr_q_w);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (imemAddr !== 11'h000) begin n_err++; $display("FAIL reset_addr: got %h want 000", imemAddr); end
    n_cmp++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", inst_data); end
    n_cmp++; if (inst_pc !== 11'h000) begin n_err++; $display("FAIL reset_pc: got %h want 000", inst_pc); end
    reset = 1'b0;
    step();
    step();
    n_cmp++; if (busy !== 1'b0 || imemAddr !== 11'h000) begin n_err++; $display("FAIL idle_hold: got busy %b addr %h want 0 000", busy, imemAddr); end
  endtask

  task automatic test_stream();
    int pops = 0;
    int cyc = 0;
    logic [AW-1:0] e;
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(AW'(i));
    run = 1'b1;
    inst_ready = 1'b1;
    step();
    n_cmp++; if (inst_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL stream_c0: got valid %b busy %b want 0 1", inst_valid, busy); end
    step();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid: got %b want 0", inst_valid); end
    step();
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stream_c2_valid: got %b want 1", inst_valid); end
    while (pops < 12 && cyc < 40) begin
      if (inst_valid && inst_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (inst_pc !== e || inst_data !== mem0(e)) begin
          n_err++; $display("FAIL stream_pop: got pc %h data %h want pc %h data %h", inst_pc, inst_data, e, mem0(e));
        end
        pops++;
      end
      cyc++;
      step();
    end
    n_cmp++; if (pops != 12 || cyc != 12) begin n_err++; $display("FAIL stream_rate: got %0d pops in %0d cycles want 12 in 12", pops, cyc); end
  endtask

  task automatic test_stall();
    int pops = 0;
    int cyc = 0;
    logic [AW-1:0] e;
    exp_q.delete();
    for (int i = 12; i < 24; i++) exp_q.push_back(AW'(i));
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_q[0] || inst_data !== mem0(exp_q[0])) begin
        n_err++; $display("FAIL stall_head: got valid %b pc %h data %h want 1 %h", inst_valid, inst_pc, inst_data, exp_q[0]);
      end
      n_cmp++;
      if (imemAddr !== exp_q[0] + 11'd2) begin
        n_err++; $display("FAIL stall_pc: got %h want %h", imemAddr, exp_q[0] + 11'd2);
      end
      step();
    end
    inst_ready = 1'b1;
    while (pops < 12 && cyc < 40) begin
      if (inst_valid && inst_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (inst_pc !== e || inst_data !== mem0(e)) begin
          n_err++; $display("FAIL stall_resume_pop: got pc %h data %h want pc %h", inst_pc, inst_data, e);
        end
        pops++;
      end
      cyc++;
      step();
    end
    n_cmp++; if (pops != 12 || cyc != 12) begin n_err++; $display("FAIL stall_resume_rate: got %0d pops in %0d cycles want 12 in 12", pops, cyc); end
  endtask

  task automatic test_redirect();
    int pops = 0;
    int cyc = 0;
    logic [AW-1:0] e;
    // Redirect while streaming: head popped in the same cycle, one request in flight.
    exp_q.delete();
    exp_q.push_back(11'd24);
    redirect_valid = 1'b1;
    redirect_pc = 11'h100;
    if (inst_valid && inst_ready) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (inst_pc !== e) begin n_err++; $display("FAIL redir_pop_consumed: got pc %h want %h", inst_pc, e); end
    end else begin
      n_cmp++; n_err++; $display("FAIL redir_pop_consumed: got valid %b want 1", inst_valid);
    end
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b want 0", inst_valid); end
    n_cmp++; if (imemAddr !== 11'h100) begin n_err++; $display("FAIL redir_addr: got %h want 100", imemAddr); end
    for (int i = 0; i < 6; i++) exp_q.push_back(11'h100 + AW'(i));
    while (pops < 6 && cyc < 20) begin
      if (inst_valid && inst_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (inst_pc !== e || inst_data !== mem0(e)) begin
          n_err++; $display("FAIL redir_pop: got pc %h data %h want pc %h", inst_pc, inst_data, e);
        end
        pops++;
      end
      cyc++;
      step();
    end
    n_cmp++; if (pops != 6) begin n_err++; $display("FAIL redir_timeout: got %0d pops want 6", pops); end
    // Redirect with a full FIFO and no pop: both entries discarded.
    inst_ready = 1'b0;
    step(); step(); step();
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL redir2_full: got valid %b want 1", inst_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 11'h200;
    step();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    n_cmp++; if (inst_valid !== 1'b0 || imemAddr !== 11'h200) begin n_err++; $display("FAIL redir2_flush: got valid %b addr %h want 0 200", inst_valid, imemAddr); end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(11'h200 + AW'(i));
    pops = 0;
    cyc = 0;
    while (pops < 4 && cyc < 20) begin
      if (inst_valid && inst_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (inst_pc !== e || inst_data !== mem0(e)) begin
          n_err++; $display("FAIL redir2_pop: got pc %h data %h want pc %h", inst_pc, inst_data, e);
        end
        pops++;
      end
      cyc++;
      step();
    end
    n_cmp++; if (pops != 4) begin n_err++; $display("FAIL redir2_timeout: got %0d pops want 4", pops); end
  endtask

  task automatic test_drain();
    int pops = 0;
    int cyc = 0;
    logic [AW-1:0] e;
    exp_q.delete();
    for (int i = 4; i < 7; i++) exp_q.push_back(11'h200 + AW'(i));
    run = 1'b0;
    while (busy && cyc < 30) begin
      if (inst_valid && inst_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (inst_pc !== e || inst_data !== mem0(e)) begin
          n_err++; $display("FAIL drain_pop: got pc %h data %h want pc %h", inst_pc, inst_data, e);
        end
        pops++;
      end
      cyc++;
      step();
    end
    n_cmp++; if (busy !== 1'b0 || pops != 3) begin n_err++; $display("FAIL drain_done: got busy %b pops %0d want 0 3", busy, pops); end
    step(); step();
    n_cmp++; if (inst_valid !== 1'b0 || imemAddr !== 11'h207) begin n_err++; $display("FAIL drain_idle: got valid %b addr %h want 0 207", inst_valid, imemAddr); end
    // Reset in the middle of DRAIN with a full FIFO.
    inst_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 6; i++) step();
    run = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b1 || inst_valid !== 1'b1) begin n_err++; $display("FAIL drain2_state: got busy %b valid %b want 1 1", busy, inst_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || imemAddr !== 11'h000 || inst_pc !== 11'h000) begin
      n_err++; $display("FAIL drain_reset: got valid %b busy %b addr %h pc %h want 0 0 000 000", inst_valid, busy, imemAddr, inst_pc);
    end
  endtask

  task automatic test_wrap();
    int pops = 0;
    int cyc = 0;
    logic [AW-1:0] e;
    n_cmp++; if (imemAddr_w !== 11'h7FE || inst_valid_w !== 1'b0) begin n_err++; $display("FAIL wrap_reset: got addr %h valid %b want 7fe 0", imemAddr_w, inst_valid_w); end
    exp_q.delete();
    exp_q.push_back(11'h7FE); exp_q.push_back(11'h7FF);
    exp_q.push_back(11'h000); exp_q.push_back(11'h001);
    reset_w = 1'b0;
    run_w = 1'b1;
    inst_ready_w = 1'b1;
    while (pops < 4 && cyc < 20) begin
      if (inst_valid_w && inst_ready_w) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (inst_pc_w !== e || inst_data_w !== mem1(e)) begin
          n_err++; $display("FAIL wrap_pop: got pc %h data %h want pc %h data %h", inst_pc_w, inst_data_w, e, mem1(e));
        end
        pops++;
      end
      cyc++;
      step();
    end
    n_cmp++; if (pops != 4) begin n_err++; $display("FAIL wrap_timeout: got %0d pops want 4", pops); end
    run_w = 1'b0;
  endtask

`ifdef INST_FETCH_PERF_CNT_EN
  task automatic test_perf();
    int pops = 0;
    int stalls = 0;
    int cyc = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin n_err++; $display("FAIL perf_reset: got %0d %0d want 0 0", fetch_count, stall_count); end
    run = 1'b1;
    while (pops < 10 && cyc < 60) begin
      if (inst_valid && pops == 4 && stalls < 3) begin
        inst_ready = 1'b0;
        stalls++;
      end else begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          pops++;
          if (pops == 10) begin
            redirect_valid = 1'b1;
            redirect_pc = 11'h000;
            run = 1'b0;
          end
        end
      end
      cyc++;
      step();
    end
    redirect_valid = 1'b0;
    step(); step(); step();
    n_cmp++; if (fetch_count !== 32'd10) begin n_err++; $display("FAIL perf_fetch: got %0d want 10", fetch_count); end
    n_cmp++; if (stall_count !== 32'd3) begin n_err++; $display("FAIL perf_stall: got %0d want 3", stall_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    reset_w = 1'b1; run_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = '0; inst_ready_w = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_drain();
    test_wrap();
`ifdef INST_FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
